// File: rtl/uart_tx_fifo_ctrl.sv
// Memory-mapped 8N1 UART transmitter: stores push bytes into a TX FIFO,
// a serializer drains the FIFO onto tx at a programmable baud divisor.
module uart_tx_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BAUD_DIV   = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned BIT_W = 3;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_BAUD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_div_q;
    logic [DIV_W-1:0]   r_baud_cnt;
    logic [BIT_W-1:0]   r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic [1:0]         w_sel;
    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_bit_end;
    logic [BIT_W-1:0]   w_bit_idx_next;
    logic               w_tx_next;
    logic               w_unused;

    assign w_sel      = address[3:2];
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_push_req = we && (w_sel == A_TXDATA);
    // A push into a full FIFO still lands when the serializer pops in the same cycle
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_unused   = ^{wd[DATA_WIDTH-1:16], address[DATA_WIDTH-1:4], address[1:0]};
    assign tx         = r_tx;

    // Serializer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, pop request and next tx level
    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = 1'b1;
        w_bit_end      = (r_baud_cnt == (r_div_q - DIV_W'(1)));
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next   = S_DATA;
                    w_bit_idx_next = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == BIT_W'(7)) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = r_shift[w_bit_idx_next];
            default: w_tx_next = 1'b1;
        endcase
    end

    // Serializer datapath; tx comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_div_q    <= DIV_W'(BAUD_DIV);
            r_baud_cnt <= '0;
        end else begin
            r_tx      <= w_tx_next;
            r_bit_idx <= w_bit_idx_next;
            if (w_pop) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_div_q    <= r_div;
                r_baud_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : (r_baud_cnt + DIV_W'(1));
            end
        end
    end

    // FIFO storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wd[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow and baud divisor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_div <= DIV_W'(BAUD_DIV);
        end else begin
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (we && (w_sel == A_STATUS) && wd[3]) begin
                r_ovf <= 1'b0;
            end
            if (we && (w_sel == A_BAUD)) begin
                r_div <= (wd[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : wd[DIV_W-1:0];
            end
        end
    end

    // Combinational read mux
    always_comb begin
        rd = '0;
        if (re) begin
            case (w_sel)
                A_STATUS: rd = DATA_WIDTH'({4'(r_count), 4'b0000, r_ovf, w_busy, w_empty, w_full});
                A_BAUD:   rd = DATA_WIDTH'(r_div);
                default:  rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: register map, frame timing,
// back-to-back frames, overflow, baud change and mid-frame reset.
module tb_uart_tx_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wd;
    logic [31:0] address;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        tx;

    int          checks;
    int          failures;
    logic        s_q[$];
    logic        e_q[$];
    logic [31:0] rv;

    uart_tx_fifo_ctrl #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(8),
        .BAUD_DIV  (434)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wd     (wd),
        .address(address),
        .we     (we),
        .re     (re),
        .rd     (rd),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock, then sample tx on the falling edge and release the strobes
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        s_q.push_back(tx);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic drive_w(input logic [1:0] a, input logic [31:0] d);
        we      = 1'b1;
        address = {28'd0, a, 2'b00};
        wd      = d;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        drive_w(a, d);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        re      = 1'b1;
        address = {28'd0, a, 2'b00};
        #1;
        d  = rd;
        re = 1'b0;
    endtask

    // Expected 8N1 waveform, div samples per bit
    task automatic add_frame(input logic [7:0] b, input int div);
        for (int bit_i = 0; bit_i < 10; bit_i++) begin
            for (int k = 0; k < div; k++) begin
                if (bit_i == 0)      e_q.push_back(1'b0);
                else if (bit_i == 9) e_q.push_back(1'b1);
                else                 e_q.push_back(b[bit_i-1]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        wd      = '0;
        address = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx_in_reset got %b want 1", tx); end
        rst_n = 1'b1;
        @(negedge clk);
        address = 32'h4;
        #1;
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rd_without_re got %h want 0", rd); end
        bus_read(2'd1, rv);
        checks++;
        if (rv !== 32'h2) begin failures++; $display("FAIL reset_status got %h want 00000002", rv); end
        bus_read(2'd2, rv);
        checks++;
        if (rv !== 32'd434) begin failures++; $display("FAIL reset_baud got %0d want 434", rv); end
        bus_read(2'd3, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL read_addr3 got %h want 0", rv); end
        bus_read(2'd0, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL read_txdata got %h want 0", rv); end
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx_idle got %b want 1", tx); end
    endtask

    task automatic test_single_frame();
        int nbad;
        bus_write(2'd2, 32'd4);
        s_q.delete();
        e_q.delete();
        e_q.push_back(1'b1);
        add_frame(8'h55, 4);
        repeat (5) e_q.push_back(1'b1);
        for (int c = 0; c < 46; c++) begin
            if (c == 20) begin
                bus_read(2'd1, rv);
                checks++;
                if (rv !== 32'h6) begin failures++; $display("FAIL busy_mid_frame got %h want 00000006", rv); end
            end
            if (c == 42) begin
                bus_read(2'd1, rv);
                checks++;
                if (rv !== 32'h2) begin failures++; $display("FAIL busy_after_frame got %h want 00000002", rv); end
            end
            if (c == 0) drive_w(2'd0, 32'h55);
            step();
        end
        for (int b = 0; b < 10; b++) begin
            nbad = 0;
            for (int j = 1 + 4 * b; j <= 4 + 4 * b; j++) if (s_q[j] !== e_q[j]) nbad++;
            checks++;
            if (nbad != 0) begin
                failures++;
                $display("FAIL frame55_bit%0d: %0d of 4 samples wrong, first sample got %b want %b",
                         b, nbad, s_q[1 + 4 * b], e_q[1 + 4 * b]);
            end
        end
        nbad = 0;
        if (s_q[0] !== 1'b1) nbad++;
        for (int j = 41; j < 46; j++) if (s_q[j] !== 1'b1) nbad++;
        checks++;
        if (nbad != 0) begin failures++; $display("FAIL frame55_idle: %0d idle samples not 1, want 0", nbad); end
    endtask

    task automatic test_back_to_back_overflow();
        logic [7:0] exp_b [10];
        int nbad;
        int first;
        exp_b = '{8'h01, 8'h80, 8'h3C, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h96, 8'h7E, 8'hC3};
        bus_write(2'd2, 32'd2);
        s_q.delete();
        e_q.delete();
        e_q.push_back(1'b1);
        for (int k = 0; k < 10; k++) begin
            add_frame(exp_b[k], 2);
            e_q.push_back(1'b1);
        end
        while (e_q.size() < 214) e_q.push_back(1'b1);
        for (int c = 0; c < 214; c++) begin
            if (c == 22) begin
                bus_read(2'd1, rv);
                checks++;
                if (rv !== 32'h801) begin failures++; $display("FAIL full_idle_status got %h want 00000801", rv); end
            end
            if (c == 23) begin
                bus_read(2'd1, rv);
                checks++;
                if (rv !== 32'h805) begin failures++; $display("FAIL push_pop_full got %h want 00000805", rv); end
            end
            if (c == 24) begin
                bus_read(2'd1, rv);
                checks++;
                if (rv !== 32'h80D) begin failures++; $display("FAIL overflow_set got %h want 0000080d", rv); end
            end
            if (c == 25) begin
                bus_read(2'd1, rv);
                checks++;
                if (rv !== 32'h805) begin failures++; $display("FAIL overflow_clear got %h want 00000805", rv); end
            end
            if (c < 9)   drive_w(2'd0, {24'd0, exp_b[c]});
            if (c == 22) drive_w(2'd0, {24'd0, exp_b[9]});
            if (c == 23) drive_w(2'd0, 32'hAA);
            if (c == 24) drive_w(2'd1, 32'h8);
            step();
        end
        checks++;
        if (s_q[0] !== 1'b1) begin failures++; $display("FAIL b2b_lead_idle got %b want 1", s_q[0]); end
        for (int k = 0; k < 10; k++) begin
            nbad  = 0;
            first = -1;
            for (int j = 1 + 21 * k; j <= 21 + 21 * k; j++) begin
                if (s_q[j] !== e_q[j]) begin
                    if (first < 0) first = j;
                    nbad++;
                end
            end
            checks++;
            if (nbad != 0) begin
                failures++;
                $display("FAIL b2b_frame%0d: %0d samples differ, first at idx %0d got %b want %b",
                         k, nbad, first, s_q[first], e_q[first]);
            end
        end
        nbad = 0;
        for (int j = 211; j < 214; j++) if (s_q[j] !== 1'b1) nbad++;
        checks++;
        if (nbad != 0) begin failures++; $display("FAIL b2b_tail_idle: %0d samples not 1, want 0", nbad); end
        bus_read(2'd1, rv);
        checks++;
        if (rv !== 32'h2) begin failures++; $display("FAIL b2b_drained got %h want 00000002", rv); end
    endtask

    task automatic test_baud();
        int nbad;
        bus_write(2'd2, 32'd1);
        bus_read(2'd2, rv);
        checks++;
        if (rv !== 32'd2) begin failures++; $display("FAIL baud_write1 got %0d want 2", rv); end
        bus_write(2'd2, 32'd0);
        bus_read(2'd2, rv);
        checks++;
        if (rv !== 32'd2) begin failures++; $display("FAIL baud_write0 got %0d want 2", rv); end
        bus_write(2'd2, 32'd4);
        s_q.delete();
        e_q.delete();
        e_q.push_back(1'b1);
        add_frame(8'h0F, 4);
        e_q.push_back(1'b1);
        add_frame(8'hF0, 8);
        while (e_q.size() < 126) e_q.push_back(1'b1);
        for (int c = 0; c < 126; c++) begin
            if (c == 0) drive_w(2'd0, 32'h0F);
            if (c == 1) drive_w(2'd0, 32'hF0);
            if (c == 5) drive_w(2'd2, 32'd8);
            step();
        end
        nbad = 0;
        for (int j = 0; j <= 41; j++) if (s_q[j] !== e_q[j]) nbad++;
        checks++;
        if (nbad != 0) begin failures++; $display("FAIL baud_old_frame: %0d samples differ, want 0", nbad); end
        nbad = 0;
        for (int j = 42; j < 126; j++) if (s_q[j] !== e_q[j]) nbad++;
        checks++;
        if (nbad != 0) begin failures++; $display("FAIL baud_new_frame: %0d samples differ, want 0", nbad); end
        bus_read(2'd2, rv);
        checks++;
        if (rv !== 32'd8) begin failures++; $display("FAIL baud_readback got %0d want 8", rv); end
    endtask

    task automatic test_reset_mid_frame();
        int nbad;
        bus_write(2'd2, 32'd4);
        s_q.delete();
        for (int c = 0; c < 19; c++) begin
            if (c == 0) drive_w(2'd0, 32'h00);
            if (c == 1) drive_w(2'd0, 32'h00);
            step();
        end
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL pre_reset_bit3 got %b want 0", tx); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL async_reset_tx got %b want 1", tx); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(2'd1, rv);
        checks++;
        if (rv !== 32'h2) begin failures++; $display("FAIL post_reset_status got %h want 00000002", rv); end
        bus_read(2'd2, rv);
        checks++;
        if (rv !== 32'd434) begin failures++; $display("FAIL post_reset_baud got %0d want 434", rv); end
        s_q.delete();
        repeat (40) step();
        nbad = 0;
        for (int j = 0; j < 40; j++) if (s_q[j] !== 1'b1) nbad++;
        checks++;
        if (nbad != 0) begin failures++; $display("FAIL post_reset_quiet: %0d samples not 1, want 0", nbad); end
        bus_read(2'd1, rv);
        checks++;
        if (rv !== 32'h2) begin failures++; $display("FAIL post_reset_idle got %h want 00000002", rv); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_frame();
        test_back_to_back_overflow();
        test_baud();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
